// File: rtl/prog_pkg.sv
// Shared definitions for the program loader: default address/word widths and the loader FSM state type.
package prog_pkg;

  localparam int N_DEF = 12;
  localparam int M_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } loader_state_e;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: 12-bit length header, data written to program memory, optional trailing
// checksum byte when LOADER_CHECKSUM_EN is defined. Holds the CPU until a load completes.
module prog_loader
  import prog_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [M-1:0] rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [N-1:0] mem_addr,
  output logic [M-1:0] mem_wdata,
  output logic         mem_we,
  output logic         cpu_hold,
  output logic         done,
  output logic         error
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  loader_state_e state_q, state_d;
  logic [N-1:0]  len_q, len_d;
  logic [N-1:0]  count_q, count_d;
  logic [N-1:0]  mem_addr_q, mem_addr_d;
  logic [M-1:0]  mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
`ifdef LOADER_CHECKSUM_EN
  logic [M-1:0]  sum_q, sum_d;
`endif

  logic xfer;
  logic [N-1:0] len_full;

  assign rx_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA)   || (state_q == S_CSUM);
  assign xfer     = rx_valid && rx_ready;
  assign len_full = {len_q[N-1:8], rx_data};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (xfer) begin
          if (rx_data[M-1:N-8] != '0) begin
            state_d = S_ERROR;
          end else begin
            len_d   = {rx_data[N-9:0], len_q[7:0]};
            state_d = S_LEN_LO;
          end
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d = len_full;
          if (len_full == '0) begin
            state_d = S_ERROR;
          end else begin
            count_d = '0;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = count_q;
          mem_wdata_d = rx_data;
          count_d     = count_q + ONE;
`ifdef LOADER_CHECKSUM_EN
          sum_d       = sum_q + rx_data;
          if (count_q == len_q - ONE) state_d = S_CSUM;
`else
          if (count_q == len_q - ONE) state_d = S_DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) state_d = (rx_data == sum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      count_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign cpu_hold  = (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign error     = (state_q == S_ERROR);

endmodule
